// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the TX side) and data-width decode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP_1 = 3'd4,
        STOP_2 = 3'd5
    } state_t;

    // num_data encodes data bits as DATA_BITS_MIN + num_data
    localparam int DATA_BITS_MIN = 5;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receive-side output port: one byte plus error flags offered under a valid/ready handshake.
interface uart_rx_fsm_if #(
    parameter int DATA_W = 8
);
    // A byte transfers on any clock edge where valid and ready are both high.
    // The producer holds valid, data and flags stable until that transfer.
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (
        output valid, data, parity_err, frame_err, overrun,
        input  ready
    );

    modport slave (
        input  valid, data, parity_err, frame_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling tick counter: strobes at the mid-start point (half) or once per bit period (full).
module uart_rx_sampler #(
    parameter int OSR = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    input  logic half,
    output logic strobe
);
    localparam int CW = $clog2(OSR);

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;

    assign limit  = half ? CW'(OSR / 2 - 1) : CW'(OSR - 1);
    assign strobe = tick & ~clear & (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= strobe ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, 5..8 data bits LSB-first, optional even parity, 1/2 stop bits.
// Define RX_SYNC_EN to pass rx through a 2-flop synchronizer (adds 2 clk of line latency).
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int OSR    = 16,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               rx,
    input  logic [1:0]         num_data,
    input  logic               parity,
    input  logic               stop_2,
    uart_rx_fsm_if.master      bus,
    output state_t             dbg_state
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP_1 = 3'd4;
    localparam logic [2:0] S_STOP_2 = 3'd5;

    logic              rx_s;
    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [2:0]        last_bit;
    logic [1:0]        num_data_s;
    logic              parity_s;
    logic              stop_2_s;
    logic [DATA_W-1:0] shift;
    logic              par_err_r;
    logic              frm_err_r;
    logic              strobe;
    logic              done;
    logic              frame_next;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              perr_q;
    logic              ferr_q;
    logic              overrun_q;

`ifdef RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];
`else
    assign rx_s = rx;
`endif

    uart_rx_sampler #(.OSR(OSR)) u_sampler (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clear  (state == S_IDLE),
        .half   (state == S_START),
        .strobe (strobe)
    );

    assign last_bit   = 3'(DATA_BITS_MIN - 1) + {1'b0, num_data_s};
    assign done       = strobe & (((state == S_STOP_1) & ~stop_2_s) | (state == S_STOP_2));
    // A low level on either stop bit marks the frame bad
    assign frame_next = ((state == S_STOP_2) & frm_err_r) | ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            num_data_s <= '0;
            parity_s   <= 1'b0;
            stop_2_s   <= 1'b0;
            shift      <= '0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state      <= S_START;
                        num_data_s <= num_data;
                        parity_s   <= parity;
                        stop_2_s   <= stop_2;
                        shift      <= '0;
                        bit_cnt    <= '0;
                        par_err_r  <= 1'b0;
                        frm_err_r  <= 1'b0;
                    end
                end
                S_START: if (strobe) state <= rx_s ? S_IDLE : S_DATA;
                S_DATA: begin
                    if (strobe) begin
                        shift[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == last_bit) state <= parity_s ? S_PARITY : S_STOP_1;
                    end
                end
                S_PARITY: begin
                    if (strobe) begin
                        par_err_r <= (^shift) ^ rx_s;
                        state     <= S_STOP_1;
                    end
                end
                S_STOP_1: begin
                    if (strobe) begin
                        frm_err_r <= ~rx_s;
                        state     <= stop_2_s ? S_STOP_2 : S_IDLE;
                    end
                end
                S_STOP_2: if (strobe) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Output register: a new byte always wins; losing an unaccepted byte pulses overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done) begin
                valid_q   <= 1'b1;
                data_q    <= shift;
                perr_q    <= par_err_r;
                ferr_q    <= frame_next;
                overrun_q <= valid_q & ~bus.ready;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.valid      = valid_q;
    assign bus.data       = data_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = overrun_q;
    assign dbg_state      = state_t'(state);
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: serial frames driven at OSR ticks per bit, outputs checked at negedge.
module tb_uart_rx_fsm;
    import uart_pkg::*;

    localparam int OSR    = 16;
    localparam int DATA_W = 8;
    localparam int TDIV   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] num_data = 2'b11;
    logic       parity = 1'b0;
    logic       stop_2 = 1'b0;
    state_t     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int ovr_cnt  = 0;
    bit ovr_mon  = 1'b0;

    uart_rx_fsm_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_fsm #(.OSR(OSR), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .num_data  (num_data),
        .parity    (parity),
        .stop_2    (stop_2),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock and tick generation
    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            tick = (c == TDIV - 1);
            c = (c == TDIV - 1) ? 0 : c + 1;
        end
    end

    always @(negedge clk) begin
        if (ovr_mon && bus.overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TDIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] val, input int nbits, input bit has_par,
                              input bit par_bit, input bit stop1, input bit has_s2, input bit stop2);
        rx = 1'b0;
        wait_ticks(OSR);
        for (int i = 0; i < nbits; i++) begin
            rx = val[i];
            wait_ticks(OSR);
        end
        if (has_par) begin
            rx = par_bit;
            wait_ticks(OSR);
        end
        rx = stop1;
        wait_ticks(OSR);
        if (has_s2) begin
            rx = stop2;
            wait_ticks(OSR);
        end
        rx = 1'b1;
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check(tag, {31'd0, bus.valid}, 32'd0);
    endtask

    initial begin
        bus.ready = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_valid", {31'd0, bus.valid}, 32'd0);
        check("reset_data", {24'd0, bus.data}, 32'd0);
        check("reset_perr", {31'd0, bus.parity_err}, 32'd0);
        check("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("reset_overrun", {31'd0, bus.overrun}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        wait_ticks(OSR);

        // 8N1 frame 0xA5
        num_data = 2'b11; parity = 1'b0; stop_2 = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("a5_valid", {31'd0, bus.valid}, 32'd1);
        check("a5_data", {24'd0, bus.data}, 32'h0000_00A5);
        check("a5_perr", {31'd0, bus.parity_err}, 32'd0);
        check("a5_ferr", {31'd0, bus.frame_err}, 32'd0);
        accept("a5_accept");
        wait_ticks(OSR);

        // 5E1, data 5'b10110 has three ones so the even parity bit is 1
        num_data = 2'b00; parity = 1'b1; stop_2 = 1'b0;
        send_frame(8'h16, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("p_ok_data", {24'd0, bus.data}, 32'h0000_0016);
        check("p_ok_perr", {31'd0, bus.parity_err}, 32'd0);
        accept("p_ok_accept");
        wait_ticks(OSR);
        send_frame(8'h16, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("p_bad_valid", {31'd0, bus.valid}, 32'd1);
        check("p_bad_data", {24'd0, bus.data}, 32'h0000_0016);
        check("p_bad_perr", {31'd0, bus.parity_err}, 32'd1);
        accept("p_bad_accept");
        wait_ticks(OSR);

        // 8N2 with second stop bit low
        num_data = 2'b11; parity = 1'b0; stop_2 = 1'b1;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("s2_data", {24'd0, bus.data}, 32'h0000_005A);
        check("s2_ferr", {31'd0, bus.frame_err}, 32'd1);
        check("s2_perr", {31'd0, bus.parity_err}, 32'd0);
        wait_ticks(2 * OSR);
        accept("s2_accept");
        stop_2 = 1'b0;

        // short low glitch in idle must not start a byte
        rx = 1'b0;
        wait_ticks(OSR / 4);
        rx = 1'b1;
        wait_ticks(2 * OSR);
        check("glitch_valid", {31'd0, bus.valid}, 32'd0);
        check("glitch_state", {29'd0, dbg_state}, 32'd0);

        // two frames without accepting: second overwrites, one overrun pulse
        ovr_mon = 1'b1;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr_first_data", {24'd0, bus.data}, 32'h0000_0011);
        check("ovr_none_yet", ovr_cnt, 32'd0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ticks(OSR);
        ovr_mon = 1'b0;
        check("ovr_count", ovr_cnt, 32'd1);
        check("ovr_valid", {31'd0, bus.valid}, 32'd1);
        check("ovr_data", {24'd0, bus.data}, 32'h0000_0022);
        accept("ovr_accept");

        // reset during DATA discards the partial byte
        rx = 1'b0;
        wait_ticks(OSR);
        rx = 1'b1;
        wait_ticks(3 * OSR);
        check("mid_state_data", {29'd0, dbg_state}, 32'd2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        wait_ticks(2 * OSR);
        check("rst_no_byte", {31'd0, bus.valid}, 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_rst_valid", {31'd0, bus.valid}, 32'd1);
        check("after_rst_data", {24'd0, bus.data}, 32'h0000_003C);
        check("after_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        accept("after_rst_accept");
        wait_ticks(OSR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
